// File: rtl/sw_asm_pkg.sv
// Shared definitions for the serial word assembler.
//   hold_state_t : state of the one-entry output holding register
//   cnt_w()      : width of the partial-word bit counter for a given WIDTH
//   DEF_WIDTH / DEF_DROP_W : default word and drop-counter widths
package sw_asm_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DROP_W = 8;

  // Counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sw_hold_reg.sv
// One-entry holding register for completed words.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   word_in       : completed word from the shift register
//   complete      : word_in is a newly completed word this cycle
//   word_rdy      : downstream accepts the held word this cycle
//   clr_ovf       : clears overflow and drop_cnt (a same-cycle drop wins)
//   word_out      : held word, stable while FULL and not accepted
//   hold_state    : EMPTY/FULL state (word_vld is FULL)
//   overflow      : sticky, a word was dropped
//   drop_cnt      : saturating count of dropped words
// Handshake: a word transfers on a rising edge where the holder is FULL
// and word_rdy=1; word_rdy is not required to wait for word_vld.
module sw_hold_reg
  import sw_asm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  word_in,
  input  logic              complete,
  input  logic              word_rdy,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  word_out,
  output hold_state_t       hold_state,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  hold_state_t       state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              drop;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    // A completion that finds the register FULL and not draining is lost.
    drop    = complete && (state_q == HOLD_FULL) && !word_rdy;
    case (state_q)
      HOLD_EMPTY: begin
        if (complete) begin
          state_d = HOLD_FULL;
          word_d  = word_in;
        end
      end
      HOLD_FULL: begin
        if (word_rdy) begin
          if (complete) word_d = word_in;   // back-to-back, no bubble
          else          state_d = HOLD_EMPTY;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)             drop_d = DROP_W'(1);
      else if (drop_q != '1)   drop_d = drop_q + DROP_W'(1);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD_EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign word_out   = word_q;
  assign hold_state = state_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Packs WIDTH consecutive valid serial bits into a parallel word and
// presents it through a one-entry valid/ready holding register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bit_in    : serial data bit
//   bit_vld   : bit_in is valid this cycle
//   flush     : discards the partial word (and this cycle's bit)
//   clr_ovf   : clears overflow and drop_cnt
//   word_out  : assembled word
//   word_vld  : word_out holds a valid word
//   word_rdy  : downstream accepts the word
//   bit_cnt   : bits collected in the partial word
//   overflow  : sticky, at least one word dropped
//   drop_cnt  : saturating dropped-word count
// All outputs come straight from flops.
module serial_word_assembler
  import sw_asm_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DROP_W    = DEF_DROP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_vld,
  input  logic                      flush,
  input  logic                      clr_ovf,
  output logic [WIDTH-1:0]          word_out,
  output logic                      word_vld,
  input  logic                      word_rdy,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, complete;
  hold_state_t      hold_state;

  always_comb begin
    accept   = bit_vld && !flush;
    complete = accept && (cnt_q == CW'(WIDTH - 1));
    // The word including the arriving bit; on completion this goes
    // straight to the holding register.
    if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], bit_in};
    else           shifted = {bit_in, sr_q[WIDTH-1:1]};

    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (complete) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  sw_hold_reg #(
    .WIDTH  (WIDTH),
    .DROP_W (DROP_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .word_in    (shifted),
    .complete   (complete),
    .word_rdy   (word_rdy),
    .clr_ovf    (clr_ovf),
    .word_out   (word_out),
    .hold_state (hold_state),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  assign word_vld = (hold_state == HOLD_FULL);
  assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0, bit_vld = 1'b0, flush = 1'b0, clr_ovf = 1'b0, word_rdy = 1'b0;

  logic [W-1:0] word_m, word_l;
  logic         vld_m, vld_l, ovf_m, ovf_l;
  logic [2:0]   cnt_m, cnt_l;
  logic [7:0]   drop_m, drop_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1), .DROP_W(8)) dut_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .clr_ovf(clr_ovf), .word_out(word_m), .word_vld(vld_m), .word_rdy(word_rdy),
    .bit_cnt(cnt_m), .overflow(ovf_m), .drop_cnt(drop_m));

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0), .DROP_W(8)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
    .clr_ovf(clr_ovf), .word_out(word_l), .word_vld(vld_l), .word_rdy(word_rdy),
    .bit_cnt(cnt_l), .overflow(ovf_l), .drop_cnt(drop_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Partial word kept as the list of received bits, in arrival order.
  logic       mq[$];
  logic       m_vld, m_ovf;
  logic [7:0] m_wm, m_wl, m_drop;
  logic       m_comp, m_drp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_vld = 1'b0; m_ovf = 1'b0; m_wm = '0; m_wl = '0; m_drop = '0;
    end else begin
      m_comp = bit_vld && !flush && (mq.size() == W - 1);
      m_drp  = m_comp && m_vld && !word_rdy;
      if (m_comp && (!m_vld || word_rdy)) begin
        for (int i = 0; i < W - 1; i++) begin
          m_wm[W-1-i] = mq[i];
          m_wl[i]     = mq[i];
        end
        m_wm[0]   = bit_in;
        m_wl[W-1] = bit_in;
        m_vld = 1'b1;
      end else if (m_vld && word_rdy) begin
        m_vld = 1'b0;
      end
      if (m_drp) begin
        m_ovf  = 1'b1;
        m_drop = clr_ovf ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
      end else if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 8'd0;
      end
      if (flush) mq.delete();
      else if (bit_vld) begin
        if (m_comp) mq.delete();
        else        mq.push_back(bit_in);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("word_vld_msb", vld_m, m_vld);
      chk("word_vld_lsb", vld_l, m_vld);
      chk("word_out_msb", word_m, m_wm);
      chk("word_out_lsb", word_l, m_wl);
      chk("bit_cnt_msb", cnt_m, mq.size());
      chk("bit_cnt_lsb", cnt_l, mq.size());
      chk("overflow_msb", ovf_m, m_ovf);
      chk("overflow_lsb", ovf_l, m_ovf);
      chk("drop_cnt_msb", drop_m, m_drop);
      chk("drop_cnt_lsb", drop_l, m_drop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends w[7] first. Leaves bit_vld=1 so words can be chained.
  task automatic send_word(input logic [7:0] w, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      bit_in  = w[i];
      bit_vld = 1'b1;
      cyc();
      if (gap && i > 0) begin
        bit_vld = 1'b0;
        cyc();
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word_vld", vld_m, 1'b0);
    chk("reset_word_out", word_m, 8'h00);
    chk("reset_bit_cnt", cnt_m, 3'd0);
    chk("reset_drop_cnt", drop_m, 8'h00);
    rst = 1'b0;
    cyc();

    // Basic word, both bit orders.
    word_rdy = 1'b1;
    send_word(8'hA5, 1'b0);
    bit_vld = 1'b0;
    chk("a5_vld", vld_m, 1'b1);
    chk("a5_msb", word_m, 8'hA5);
    chk("a5_lsb", word_l, 8'hA5);
    chk("a5_bit_cnt", cnt_m, 3'd0);
    cyc();
    chk("a5_vld_one_cycle", vld_m, 1'b0);

    send_word(8'hC0, 1'b0);   // bits 1,1,0,0,0,0,0,0
    bit_vld = 1'b0;
    chk("c0_msb", word_m, 8'hC0);
    chk("c0_lsb", word_l, 8'h03);
    cyc();

    // Gapped input.
    send_word(8'hC3, 1'b1);
    bit_vld = 1'b0;
    chk("gap_c3_vld", vld_m, 1'b1);
    chk("gap_c3_word", word_m, 8'hC3);
    cyc();

    // Backpressure and drops.
    word_rdy = 1'b0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    bit_vld = 1'b0;
    chk("bp_word_msb", word_m, 8'h11);
    chk("bp_word_lsb", word_l, 8'h88);
    chk("bp_overflow", ovf_m, 1'b1);
    chk("bp_drop_cnt", drop_m, 8'd2);
    word_rdy = 1'b1;
    cyc();
    chk("bp_accept_vld", vld_m, 1'b0);
    chk("bp_sticky_ovf", ovf_m, 1'b1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clr_overflow", ovf_m, 1'b0);
    chk("clr_drop_cnt", drop_m, 8'd0);

    // Full-rate streaming.
    for (int k = 1; k <= 4; k++) begin
      send_word(8'(k), 1'b0);
      chk("stream_vld", vld_m, 1'b1);
      chk("stream_word", word_m, 8'(k));
      chk("stream_ovf", ovf_m, 1'b0);
    end
    bit_vld = 1'b0;
    cyc();

    // Flush.
    for (int i = 0; i < 5; i++) begin
      bit_in = 1'b1; bit_vld = 1'b1;
      cyc();
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0; bit_vld = 1'b0;
    chk("flush_bit_cnt", cnt_m, 3'd0);
    send_word(8'hF0, 1'b0);
    bit_vld = 1'b0;
    chk("flush_f0_word", word_m, 8'hF0);
    cyc();

    // Asynchronous reset mid-word with a held word.
    word_rdy = 1'b0;
    send_word(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b1;
      cyc();
    end
    bit_vld = 1'b0;
    chk("pre_rst_vld", vld_m, 1'b1);
    chk("pre_rst_cnt", cnt_m, 3'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", vld_m, 1'b0);
    chk("async_rst_word", word_m, 8'h00);
    chk("async_rst_cnt", cnt_m, 3'd0);
    chk("async_rst_word_lsb", word_l, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();

    // Drop counter saturation.
    word_rdy = 1'b0;
    for (int k = 0; k < 260; k++) send_word(8'($urandom), 1'b0);
    bit_vld = 1'b0;
    chk("sat_drop_cnt", drop_m, 8'hFF);
    chk("sat_overflow", ovf_m, 1'b1);
    word_rdy = 1'b1;
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;

    // Randomized traffic.
    repeat (3000) begin
      bit_in   = 1'($urandom_range(0, 1));
      bit_vld  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      clr_ovf  = ($urandom_range(0, 29) == 0);
      word_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    bit_vld = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
